int_arb: RTL
============

# int_arb

Interrupt arbiter between the Unibus-style peripheral register blocks (console DL11, disk, line clock) and the CPU's interrupt input. Each device drives a level interrupt request with its own vector and bus-request level. The arbiter edge-detects the requests into pending flags and picks the highest-priority eligible pending request. It presents that request's vector to the CPU with a stable request/acknowledge handshake, then reports the grant back to the device.

## Interface
Parameters:
- NREQ, 4, number of requesters; index 0 has the highest tie-break priority.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- req  in  NREQ  level interrupt request per device (e.g. a DL11 interrupt output).
- req_vec  in  8*NREQ  vector per device; bits [8i+7:8i] belong to requester i.
- req_lvl  in  3*NREQ  BR level per device (4..7); bits [3i+2:3i] belong to requester i.
- cpu_ipl  in  3  current CPU priority (PSW[7:5]).
- int_ack  in  1  CPU vector-fetch acknowledge; level, held until the CPU sees int_req drop.
- int_req  out  1  interrupt request to the CPU.
- int_vector  out  8  vector of the granted request; valid while int_req=1.
- int_ipl  out  3  level of the granted request; valid while int_req=1.
- ack_dev  out  NREQ  one-cycle grant pulse to the serviced device.

## Operation
- req_q register holds req delayed by one clock. rise[i] = req[i] & ~req_q[i].
- pending[i] update per edge, in this priority order:
  - Set on rise[i]. Set overrides clear.
  - Cleared when requester i is acknowledged.
  - Cleared when req[i]=0, which means the device withdrew the request.
- eligible[i] = pending[i] & (req_lvl[i] > cpu_ipl).
- Winner is the eligible requester with the highest req_lvl. On equal levels, the lowest index wins.
- State machine with states IDLE, REQ and HOLD:
  - IDLE: if any eligible, latch win_idx, int_vector=req_vec[win], int_ipl=req_lvl[win], set int_req=1, go to REQ. Otherwise stay.
  - REQ: the latched values are frozen; there is no preemption by later or higher requests.
    - If int_ack=1: clear pending[win_idx], pulse ack_dev[win_idx] on the next cycle, drop int_req, go to HOLD.
    - Else if pending[win_idx]=0 or req_lvl[win_idx] <= cpu_ipl: drop int_req, go to IDLE. No ack_dev pulse.
  - HOLD: wait for int_ack=0, then go to IDLE.
- int_ack in IDLE or HOLD has no effect on pending.
- int_vector and int_ipl keep their last values when int_req=0. They only change on a latch in IDLE.
- Reset values: state=IDLE, int_req=0, int_vector=0, int_ipl=0, ack_dev=0, pending=0, req_q=0.
  - A req held high across reset release therefore registers as a rising edge at the first clock after release.
- Reset asserted mid-handshake forces IDLE on that edge and discards all pending requests.

## Timing
- req rises before edge k:
  - pending set at edge k.
  - int_req=1 after edge k+1.
  - This 2-cycle latency applies when the arbiter is in IDLE and the request is eligible.
- int_ack sampled high at edge m in REQ:
  - int_req=0 and ack_dev[win]=1 after edge m.
  - ack_dev=0 after edge m+1.
- HOLD lasts until the edge where int_ack=0 is sampled. The next grant is earliest one cycle after that.
- Back-to-back service of two pending requests: with int_ack high for exactly one cycle, int_req drops for a minimum of 2 cycles between grants.
- Simultaneous rise and ack on the same requester: pending stays 1 and the request is re-arbitrated after HOLD.
- Simultaneous rises on several requesters resolve in one arbitration by level, then by index.
- A level req that stays high does not re-request after its ack. A new request requires req to go low then high again, as DL11 ready/enable toggling does.

## Test plan
- Single request, requester 1 (vec 0o60, lvl 4), cpu_ipl=0: raise req[1] → int_req=1 two cycles later, int_vector=0o60, int_ipl=4. Pulse int_ack one cycle → ack_dev=4'b0010 for exactly one cycle, int_req=0.
- Priority and tie-break: raise req[0] (lvl 4, 0o64), req[2] (lvl 5, 0o220) and req[3] (lvl 5, 0o100) on the same edge.
  - Grants in order 0o220, 0o100, 0o64.
  - Each grant needs its own ack, and int_req stays low ≥2 cycles between grants.
- Masking: cpu_ipl=4 with req[1] at lvl 4 → no int_req. Lower cpu_ipl to 3 → int_req=1 on the next cycle with vector 0o60.
- Withdrawal: in REQ, drop req[win] before ack → int_req=0 next cycle, no ack_dev pulse. Raising cpu_ipl to 7 in REQ gives the same result, but pending stays set and the request is re-granted when cpu_ipl returns to 0.
- Level hold and re-edge:
  - req[1] held high after its ack → no second int_req.
  - Drop req[1] for one cycle and raise it again → new grant.
  - Rise coinciding with the ack edge → re-granted after HOLD.
- Reset: assert reset=0 while in REQ → all outputs 0 next edge. Release with req[0] high → grant with req_vec[0] two cycles after release.

Source files
------------

// File: rtl/int_arb.sv
// Interrupt arbiter: edge-detects level requests into pending flags, grants the
// highest-level eligible one to the CPU over a held request/acknowledge handshake.
module int_arb #(
    parameter int NREQ = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_req_vec,
    input  logic [3*NREQ-1:0] i_req_lvl,
    input  logic [2:0]        i_cpu_ipl,
    input  logic              i_int_ack,
    output logic              o_int_req,
    output logic [7:0]        o_int_vector,
    output logic [2:0]        o_int_ipl,
    output logic [NREQ-1:0]   o_ack_dev
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // state  | meaning
    // S_IDLE | no request presented; arbitrate eligible pending requests
    // S_REQ  | int_req high, granted vector/level frozen until ack or drop-out
    // S_HOLD | acked; wait for the CPU to release int_ack
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_req_q, r_pending, r_ack_dev;
    logic [NREQ-1:0] w_rise, w_elig, w_ack_clr, w_pending_nxt, w_ack_dev_nxt, w_win_onehot;
    logic [IW-1:0]   r_win_idx, w_win_idx, w_win_idx_nxt;
    logic            r_int_req, w_int_req_nxt, w_any_elig, w_cur_pend;
    logic [7:0]      r_int_vector, w_int_vector_nxt, w_cand_vec;
    logic [2:0]      r_int_ipl, w_int_ipl_nxt, w_best_lvl, w_cur_lvl;

    assign w_rise = i_req & ~r_req_q;

    // Strictly-greater compare keeps the lower index on equal levels.
    always_comb begin
        w_elig     = '0;
        w_any_elig = 1'b0;
        w_win_idx  = '0;
        w_best_lvl = '0;
        w_cand_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = r_pending[i] && (i_req_lvl[3*i +: 3] > i_cpu_ipl);
            if (w_elig[i] && (!w_any_elig || (i_req_lvl[3*i +: 3] > w_best_lvl))) begin
                w_any_elig = 1'b1;
                w_win_idx  = IW'(i);
                w_best_lvl = i_req_lvl[3*i +: 3];
                w_cand_vec = i_req_vec[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        w_cur_lvl    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == r_win_idx) begin
                w_win_onehot[i] = 1'b1;
                w_cur_lvl       = i_req_lvl[3*i +: 3];
            end
        end
        w_cur_pend = |(r_pending & w_win_onehot);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_int_req_nxt    = r_int_req;
        w_int_vector_nxt = r_int_vector;
        w_int_ipl_nxt    = r_int_ipl;
        w_win_idx_nxt    = r_win_idx;
        w_ack_dev_nxt    = '0;
        w_ack_clr        = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_elig) begin
                    w_win_idx_nxt    = w_win_idx;
                    w_int_vector_nxt = w_cand_vec;
                    w_int_ipl_nxt    = w_best_lvl;
                    w_int_req_nxt    = 1'b1;
                    w_state_nxt      = S_REQ;
                end
            end
            S_REQ: begin
                if (i_int_ack) begin
                    w_ack_clr     = w_win_onehot;
                    w_ack_dev_nxt = w_win_onehot;
                    w_int_req_nxt = 1'b0;
                    w_state_nxt   = S_HOLD;
                end else if (!w_cur_pend || (w_cur_lvl <= i_cpu_ipl)) begin
                    w_int_req_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!i_int_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A fresh rise wins over an ack clear on the same edge.
    assign w_pending_nxt = w_rise | (r_pending & ~w_ack_clr & i_req);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_req_q      <= '0;
            r_pending    <= '0;
            r_win_idx    <= '0;
            r_int_req    <= 1'b0;
            r_int_vector <= '0;
            r_int_ipl    <= '0;
            r_ack_dev    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_q      <= i_req;
            r_pending    <= w_pending_nxt;
            r_win_idx    <= w_win_idx_nxt;
            r_int_req    <= w_int_req_nxt;
            r_int_vector <= w_int_vector_nxt;
            r_int_ipl    <= w_int_ipl_nxt;
            r_ack_dev    <= w_ack_dev_nxt;
        end
    end

    assign o_int_req    = r_int_req;
    assign o_int_vector = r_int_vector;
    assign o_int_ipl    = r_int_ipl;
    assign o_ack_dev    = r_ack_dev;

endmodule
